mem_burst_master: RTL and testbench

// - Initiator for the 128x8 single-port sync memory: turns one burst command (addr, length, dir) into per-cycle
//   mem_wr_en/mem_rd_en/mem_addr/mem_wdata drive, streams write data in and read data out over valid/ready.
// - Sits between a host/test sequencer and the memory; owns all memory-port timing, incl. 1-cycle read latency.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_rd_buf.sv | 56 +++++
 rtl/mem_burst_master.sv | 136 +++++++++++++
 tb/tb_mem_burst_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared sizing and FSM state type for the burst master and its read buffer.
package mem_pkg;

  localparam int unsigned AW_DEF    = 7;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned MEM_DEPTH = 1 << AW_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/mem_rd_buf.sv
// Two-entry FIFO holding read beats between memory capture and the consumer.
module mem_rd_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] data_q [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = data_q[rptr_q];

  // Accept push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = wptr_q ^ do_push;
    rptr_d  = rptr_q ^ do_pop;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset drops any buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
      data_q  <= '{default: '0};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) data_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port sync memory: one command becomes a
// stream of per-cycle memory accesses, with write data in and read data out
// over valid/ready.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          inflight_q, inflight_d;
  logic          done_q, done_d;

  logic          buf_full, buf_empty, buf_push, pop;
  logic [1:0]    buf_count;
  logic [2:0]    outstanding;
  logic          credit;

  assign rd_valid = ~buf_empty;
  assign pop      = rd_valid & rd_ready;
  assign mem_addr = addr_q;
  // Capture is guarded against a full buffer; the credit rule keeps this from ever firing.
  assign buf_push = inflight_q & (~buf_full | pop);

  // Beats issued but not yet consumed, counting this cycle's pop as already freed
  // so a streaming consumer sustains one beat per cycle.
  assign outstanding = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign credit      = (outstanding < 3'd2);

  mem_rd_buf #(.DW(DW)) u_rd_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (buf_push),
    .push_data_i (mem_rdata),
    .pop_i       (pop),
    .head_o      (rd_data),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  // Next-state, counter updates and memory-port drive.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    cmd_ready  = 1'b0;
    wd_ready   = 1'b0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wdata  = '0;
    done       = done_q;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wd_ready  = 1'b1;
        mem_wr_en = wd_valid;
        mem_wdata = wd_data;
        if (wd_valid) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - AW'(1);
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (credit) begin
          mem_rd_en  = 1'b1;
          addr_d     = addr_q + AW'(1);
          rem_d      = rem_q - AW'(1);
          inflight_d = 1'b1;
          if (rem_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && buf_empty) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench: burst master driving a behavioural 128x8 sync memory.
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [6:0] cmd_addr, cmd_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_wr_en, mem_rd_en;

  always #5 clk = ~clk;

  mem_burst_master #(.AW(7), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  // Behavioural memory: sync write, 1-cycle read, cleared by the shared reset.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  model [128];
  logic [7:0]  wbuf  [128];
  logic [14:0] wq [$];
  logic [7:0]  rq [$];
  logic [6:0]  aq [$];
  int issued = 0, popped = 0, first_pop = -1, last_pop = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every memory write, read issue and read beat against the queues.
  always @(negedge clk) begin
    logic [14:0] we;
    int          pop_now;
    if (!rst) begin
      pop_now = int'(rd_valid & rd_ready);
      if (mem_wr_en || mem_rd_en) chk("wr_rd_exclusive", int'(mem_wr_en & mem_rd_en), 0);
      if (mem_wr_en) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got write addr %0h, expected none", mem_addr);
        end else begin
          we = wq.pop_front();
          chk("wr_addr", int'(mem_addr), int'(we[14:8]));
          chk("wr_data", int'(mem_wdata), int'(we[7:0]));
        end
      end
      if (mem_rd_en) begin
        checks++;
        if (issued - popped - pop_now >= 2) begin
          errors++;
          $display("FAIL rd_credit: got %0d outstanding at issue, expected < 2", issued - popped - pop_now);
        end
        if (aq.size() == 0) chk("rd_issue_unexpected", int'(mem_addr), -1);
        else chk("rd_addr", int'(mem_addr), int'(aq.pop_front()));
        issued++;
      end
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("rd_beat_unexpected", int'(rd_data), -1);
        else chk("rd_data", int'(rd_data), int'(rq.pop_front()));
        popped++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  // Offer a command (call just after a posedge); returns just after the accepting edge.
  task automatic send_cmd(input logic w, input logic [6:0] a, input logic [6:0] l);
    int k = 0;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 200);
    chk("cmd_accept_timeout", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic read_expect(input logic [6:0] a, input logic [6:0] l);
    logic [6:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 7'(i);
      rq.push_back(model[ad]);
      aq.push_back(ad);
    end
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic read_finish(input logic [6:0] l, input bit mode);
    int k = 0;
    int got = 0;
    int dcyc = -1;
    while (got == 0 && k < 400) begin
      if (mode) rd_ready = (k >= 6 && k < 11) ? 1'b0 : ((k % 2) == 0);
      else      rd_ready = 1'b1;
      @(negedge clk);
      if (done) begin got = 1; dcyc = cyc; end
      @(posedge clk); #1;
      k++;
    end
    rd_ready = 1'b1;
    chk("read_done_seen", got, 1);
    chk("read_beats_left", rq.size(), 0);
    chk("read_issues_left", aq.size(), 0);
    if (!mode) chk("read_consecutive_span", last_pop - first_pop, int'(l));
    chk("read_done_after_last_beat", dcyc, last_pop + 1);
  endtask

  task automatic read_burst(input logic [6:0] a, input logic [6:0] l, input bit mode);
    read_expect(a, l);
    send_cmd(1'b0, a, l);
    read_finish(l, mode);
  endtask

  // Write burst from wbuf; gap inserts idle beats, hold offers a read command throughout.
  task automatic write_burst(input logic [6:0] a, input logic [6:0] l, input bit gap, input bit hold);
    logic [6:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 7'(i);
      wq.push_back({ad, wbuf[i]});
      model[ad] = wbuf[i];
    end
    send_cmd(1'b1, a, l);
    if (hold) begin
      read_expect(a, l);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    end
    for (int i = 0; i <= int'(l); i++) begin
      if (gap && (i % 2) == 1) begin
        wd_valid = 1'b0;
        @(negedge clk);
        if (hold) chk("cmd_ready_during_write", int'(cmd_ready), 0);
        @(posedge clk); #1;
      end
      wd_valid = 1'b1;
      wd_data  = wbuf[i];
      @(negedge clk);
      chk("wd_ready", int'(wd_ready), 1);
      if (hold) chk("cmd_ready_during_write", int'(cmd_ready), 0);
      @(posedge clk); #1;
    end
    wd_valid = 1'b0;
    wd_data  = 8'h00;
    @(negedge clk);
    chk("done_after_write", int'(done), 1);
    if (hold) chk("cmd_ready_after_write", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
    chk("write_queue_empty", wq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin model[i] = 8'h00; wbuf[i] = 8'h00; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wd_ready", int'(wd_ready), 0);
    chk("rst_mem_en", int'({mem_wr_en, mem_rd_en}), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    @(posedge clk); #1;

    // Basic write then read back
    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    write_burst(7'h10, 7'd3, 1'b0, 1'b0);
    read_burst(7'h10, 7'd3, 1'b0);

    // Address wrap at the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(7'h7E, 7'd3, 1'b0, 1'b0);
    read_burst(7'h7E, 7'd3, 1'b0);

    // Read under a toggling/stalling consumer
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h50 + 8'(i);
    write_burst(7'h20, 7'd7, 1'b0, 1'b0);
    read_burst(7'h20, 7'd7, 1'b1);

    // Reset mid-read: abort, no done, memory cleared
    read_expect(7'h20, 7'd7);
    send_cmd(1'b0, 7'h20, 7'd7);
    rd_ready = 1'b1;
    k = popped;
    for (int i = 0; i < 50 && popped - k < 2; i++) begin
      @(negedge clk); @(posedge clk); #1;
    end
    chk("reset_test_two_beats", popped - k, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete(); aq.delete();
    issued = 0; popped = 0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    @(negedge clk);
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    @(posedge clk); #1;
    read_burst(7'h20, 7'd7, 1'b0);

    // Command held during a gapped write; accepted once back in IDLE
    wbuf[0] = 8'hC1; wbuf[1] = 8'hC2; wbuf[2] = 8'hC3;
    write_burst(7'h30, 7'd2, 1'b1, 1'b1);
    read_finish(7'd2, 1'b0);

    // Full-depth burst visits every address once
    for (int i = 0; i < 128; i++) wbuf[i] = 8'(i) ^ 8'h5A;
    write_burst(7'h00, 7'd127, 1'b0, 1'b0);
    read_burst(7'h00, 7'd127, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
